// File: rtl/clock_pkg.sv
// Shared types and limits for the digital clock mode/set controller.
// edit_field is the raw state encoding, so the enum values are fixed at 0..3.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_SET_SEC = 2'd3
  } clock_state_e;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [4:0] HR_MAX  = 5'd23;

  function automatic logic [5:0] wrap_inc(input logic [5:0] value, input logic [5:0] max_value);
    return (value == max_value) ? 6'd0 : value + 6'd1;
  endfunction

  function automatic clock_state_e next_mode(input clock_state_e s);
    case (s)
      ST_RUN:     return ST_SET_HR;
      ST_SET_HR:  return ST_SET_MIN;
      ST_SET_MIN: return ST_SET_SEC;
      default:    return ST_RUN;
    endcase
  endfunction

endpackage

// File: rtl/timekeeper_ctrl_btn_conditioner.sv
// Raw button -> 2-FF synchronizer, optional debounce (DEBOUNCE_EN), one-cycle press pulse.
// Pin change sampled at edge k gives a press pulse after edge k+3 (plus DEB_CYCLES when debounced).
module btn_conditioner
`ifdef DEBOUNCE_EN
#(
  parameter int DEB_CYCLES = 16
)
`endif
(
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic press
);

  logic sync1_reg, sync2_reg, level_reg, level_d_reg, press_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      level_d_reg <= 1'b0;
      press_reg   <= 1'b0;
    end else begin
      sync1_reg   <= btn;
      sync2_reg   <= sync1_reg;
      level_d_reg <= level_reg;
      press_reg   <= level_reg & ~level_d_reg;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic [CW-1:0] deb_cnt_reg;

  // The level follows the synchronized pin only after it has differed for DEB_CYCLES clocks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_reg   <= 1'b0;
      deb_cnt_reg <= '0;
    end else if (sync2_reg == level_reg) begin
      deb_cnt_reg <= '0;
    end else if (deb_cnt_reg == CW'(DEB_CYCLES)) begin
      level_reg   <= sync2_reg;
      deb_cnt_reg <= '0;
    end else begin
      deb_cnt_reg <= deb_cnt_reg + 1'b1;
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) level_reg <= 1'b0;
    else          level_reg <= sync2_reg;
  end
`endif

  assign press = press_reg;

endmodule

// File: rtl/timekeeper_ctrl.sv
// Clock mode/set controller: 1 s tick prescaler, set-time FSM, load strobes, blink.
// Optional button debounce is enabled by defining DEBOUNCE_EN.
module timekeeper_ctrl
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
`ifdef DEBOUNCE_EN
  , parameter int DEB_CYCLES = 16
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [5:0] sec_in,
  input  logic [5:0] min_in,
  input  logic [4:0] hr_in,
  output logic       tick,
  output logic       load_sec,
  output logic       load_min,
  output logic       load_hr,
  output logic [5:0] load_val,
  output logic [1:0] edit_field,
  output logic       blink
);

  localparam int HALF = TICK_DIV / 2;
  localparam int PW   = $clog2(TICK_DIV);
  localparam int BW   = $clog2(HALF);

  logic [1:0] btn_raw;
  logic [1:0] btn_press;
  assign btn_raw = {btn_inc, btn_mode};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
`ifdef DEBOUNCE_EN
    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
`else
    btn_conditioner u_btn (
`endif
      .clk     (clk),
      .reset_n (reset_n),
      .btn     (btn_raw[gi]),
      .press   (btn_press[gi])
    );
  end

  clock_state_e  state_reg, state_next;
  logic [PW-1:0] presc_reg;
  logic [BW-1:0] blink_cnt_reg;
  logic          tick_reg, blink_reg, load_sec_reg, load_min_reg, load_hr_reg;
  logic [5:0]    load_val_reg;

  // A mode press always wins; a coincident inc press is simply never looked at.
  assign state_next = btn_press[0] ? next_mode(state_reg) : state_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_RUN;
      presc_reg     <= '0;
      blink_cnt_reg <= '0;
      tick_reg      <= 1'b0;
      blink_reg     <= 1'b0;
      load_sec_reg  <= 1'b0;
      load_min_reg  <= 1'b0;
      load_hr_reg   <= 1'b0;
      load_val_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      tick_reg     <= 1'b0;
      load_sec_reg <= 1'b0;
      load_min_reg <= 1'b0;
      load_hr_reg  <= 1'b0;
      load_val_reg <= '0;
      if (state_next != state_reg) begin
        // Any state change restarts both the tick period and the blink phase.
        presc_reg     <= '0;
        blink_cnt_reg <= '0;
        blink_reg     <= (state_next != ST_RUN);
      end else if (state_reg == ST_RUN) begin
        blink_reg     <= 1'b0;
        blink_cnt_reg <= '0;
        if (presc_reg == PW'(TICK_DIV - 1)) begin
          tick_reg  <= 1'b1;
          presc_reg <= '0;
        end else begin
          presc_reg <= presc_reg + 1'b1;
        end
      end else begin
        presc_reg <= '0;
        if (blink_cnt_reg == BW'(HALF - 1)) begin
          blink_cnt_reg <= '0;
          blink_reg     <= ~blink_reg;
        end else begin
          blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
        if (btn_press[1]) begin
          case (state_reg)
            ST_SET_HR: begin
              load_hr_reg  <= 1'b1;
              load_val_reg <= wrap_inc({1'b0, hr_in}, {1'b0, HR_MAX});
            end
            ST_SET_MIN: begin
              load_min_reg <= 1'b1;
              load_val_reg <= wrap_inc(min_in, MIN_MAX);
            end
            default: begin
              load_sec_reg <= 1'b1;
              load_val_reg <= wrap_inc(sec_in, SEC_MAX);
            end
          endcase
        end
      end
    end
  end

  assign tick       = tick_reg;
  assign load_sec   = load_sec_reg;
  assign load_min   = load_min_reg;
  assign load_hr    = load_hr_reg;
  assign load_val   = load_val_reg;
  assign edit_field = state_reg;
  assign blink      = blink_reg;

endmodule
